// File: rtl/uart_tx_fc.sv
// RTS/CTS flow-controlled UART transmitter: byte stream in, FIFO-buffered,
// serialised as start + 8 data (LSB first) + optional parity + 1 or 2 stop bits.
module uart_tx_fc #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       rts,
    input  logic       cts,
    output logic       busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    DATA_LAST  = 3'd7;
    localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic          PAR_INV    = (PARITY_ODD != 0);
    localparam logic          PAR_ON     = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CTS,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic            w_full;
    logic [7:0]      w_head;

    logic            r_cts_meta;
    logic            r_cts_sync;

    logic [7:0]      r_shift;
    logic            r_parity;
    logic [BW-1:0]   r_baud_cnt;
    logic [2:0]      r_bit_cnt;
    logic            r_tx;
    logic            r_rts;
    logic            r_busy;

    logic            w_baud_done;
    logic            w_timed;
    logic            w_active;
    logic            w_tx_next;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == FULL_COUNT);
    assign w_push   = tx_valid && !w_full;
    assign w_head   = r_mem[r_rd_ptr];
    assign tx_ready = !w_full;
    assign tx       = r_tx;
    assign rts      = r_rts;
    assign busy     = r_busy;

    // FIFO storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // cts comes from another domain; resets to the deasserted level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cts_meta <= 1'b1;
            r_cts_sync <= 1'b1;
        end else begin
            r_cts_meta <= cts;
            r_cts_sync <= r_cts_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_baud_done = (r_baud_cnt == BAUD_LAST);
    assign w_timed     = (r_state == S_START) || (r_state == S_DATA) ||
                         (r_state == S_PARITY) || (r_state == S_STOP);
    assign w_active    = !w_empty || (r_state != S_IDLE);

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_next = S_WAIT_CTS;
                end
            end
            S_WAIT_CTS: begin
                if (!r_cts_sync && !w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_tx_next = 1'b0;
                if (w_baud_done) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_next = r_shift[0];
                if (w_baud_done && (r_bit_cnt == DATA_LAST)) begin
                    w_state_next = PAR_ON ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                w_tx_next = r_parity;
                if (w_baud_done) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_baud_done && (r_bit_cnt == STOP_LAST)) begin
                    w_state_next = w_empty ? S_IDLE : S_WAIT_CTS;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // tx follows the state one cycle late, so every bit is exactly one baud wide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= 1'b1;
            r_rts      <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_tx   <= w_tx_next;
            r_rts  <= !w_active;
            r_busy <= w_active;
            if (w_pop) begin
                r_shift  <= w_head;
                r_parity <= (^w_head) ^ PAR_INV;
            end else if ((r_state == S_DATA) && w_baud_done) begin
                r_shift <= {1'b0, r_shift[7:1]};
            end
            if (w_state_next != r_state) begin
                r_baud_cnt <= '0;
                r_bit_cnt  <= '0;
            end else if (w_timed) begin
                if (w_baud_done) begin
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                end else begin
                    r_baud_cnt <= r_baud_cnt + BW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fc.sv
// Testbench for uart_tx_fc: directed timing sequences, a parity table on two
// parity-enabled instances, and a randomised stream checked against a byte queue.
module tb_uart_tx_fc;
    localparam int C = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] d0 = 8'h00;
    logic       v0 = 1'b0;
    logic       c0 = 1'b0;
    logic       rdy0, tx0, rts0, busy0;

    logic [7:0] d1 = 8'h00;
    logic       v1 = 1'b0;
    logic       c1 = 1'b0;
    logic       rdy1, tx1, rts1, busy1;
    logic       rdy2, tx2, rts2, busy2;

    uart_tx_fc #(.CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst(rst), .tx_data(d0), .tx_valid(v0), .tx_ready(rdy0),
        .tx(tx0), .rts(rts0), .cts(c0), .busy(busy0));

    uart_tx_fc #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1), .tx_ready(rdy1),
        .tx(tx1), .rts(rts1), .cts(c1), .busy(busy1));

    uart_tx_fc #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1), .tx_ready(rdy2),
        .tx(tx2), .rts(rts2), .cts(c1), .busy(busy2));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [3:0] cts_d = 4'hF;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        cts_d <= {cts_d[2:0], c0};
    end

    typedef struct packed {
        logic [7:0] data;
        logic       par_odd;
        logic       par_even;
    } vec_t;
    vec_t tbl [6];

    logic [7:0] q [$];
    bit drv_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic line(input int sel);
        case (sel)
            0:       return tx0;
            1:       return tx1;
            default: return tx2;
        endcase
    endfunction

    // Reference frame from the line rules: start 0, data LSB first, parity, stop 1s.
    function automatic logic [11:0] build_frame(input logic [7:0] d, input int pen, input int podd);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (pen != 0) f[9] = (^d) ^ (podd != 0);
        return f;
    endfunction

    task automatic wait_fall(input int sel, input int budget, output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (line(sel) == 1'b0) begin
                t  = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Entered on the negedge holding the first start-bit sample; returns on the last stop sample.
    task automatic read_frame(input int sel, input int nbits, output logic [11:0] bits, output bit stable);
        logic v;
        bits   = '1;
        stable = 1'b1;
        v      = 1'b1;
        for (int b = 0; b < nbits; b++) begin
            for (int k = 0; k < C; k++) begin
                if (!(b == 0 && k == 0)) @(negedge clk);
                if (k == 0) v = line(sel);
                else if (line(sel) !== v) stable = 1'b0;
            end
            bits[b] = v;
        end
    endtask

    task automatic push0(input logic [7:0] b, output int n);
        @(negedge clk);
        d0 = b;
        v0 = 1'b1;
        @(negedge clk);
        n  = cyc;
        v0 = 1'b0;
    endtask

    task automatic push1(input logic [7:0] b, output int n);
        @(negedge clk);
        d1 = b;
        v1 = 1'b1;
        @(negedge clk);
        n  = cyc;
        v1 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t, t1, t2, k, last, idle;
        bit ok, ok1, ok2, st, s1, s2, stayed;
        logic [11:0] fr, f1, f2, e1, e2;

        tbl[0] = '{data: 8'h07, par_odd: 1'b0, par_even: 1'b1};
        tbl[1] = '{data: 8'h00, par_odd: 1'b1, par_even: 1'b0};
        tbl[2] = '{data: 8'hFF, par_odd: 1'b1, par_even: 1'b0};
        tbl[3] = '{data: 8'h80, par_odd: 1'b0, par_even: 1'b1};
        tbl[4] = '{data: 8'h5A, par_odd: 1'b1, par_even: 1'b0};
        tbl[5] = '{data: 8'hA4, par_odd: 1'b0, par_even: 1'b1};

        repeat (3) @(negedge clk);
        check("reset_tx", tx0, 1);
        check("reset_rts", rts0, 1);
        check("reset_busy", busy0, 0);
        check("reset_ready", rdy0, 1);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single byte 0xA5, latency and rts/busy framing
        push0(8'hA5, n);
        check("t1_rts_at_push", rts0, 1);
        @(negedge clk);
        check("t1_rts_low", rts0, 0);
        check("t1_busy_high", busy0, 1);
        wait_fall(0, 20, t, ok);
        check("t1_fall_seen", ok, 1);
        check("t1_latency", t - n, 3);
        read_frame(0, 10, fr, st);
        check("t1_stable", st, 1);
        check("t1_frame", fr, build_frame(8'hA5, 0, 0));
        check("t1_rts_in_stop", rts0, 0);
        @(negedge clk);
        check("t1_rts_release", rts0, 1);
        check("t1_busy_release", busy0, 0);
        check("t1_tx_idle", tx0, 1);

        // CTS gating, deassert mid-frame
        c0 = 1'b1;
        repeat (4) @(negedge clk);
        push0(8'h3C, n);
        stayed = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (tx0 !== 1'b1) stayed = 1'b0;
        end
        check("t2_held_idle", stayed, 1);
        check("t2_rts_low", rts0, 0);
        c0 = 1'b0;
        k = cyc + 1;
        fork
            begin
                repeat (76) @(negedge clk);
                c0 = 1'b1;
            end
        join_none
        wait_fall(0, 20, t, ok);
        check("t2_fall_seen", ok, 1);
        check("t2_cts_latency", t - k, 3);
        read_frame(0, 10, fr, st);
        check("t2_stable", st, 1);
        check("t2_frame", fr, build_frame(8'h3C, 0, 0));
        c0 = 1'b0;
        repeat (5) @(negedge clk);

        // FIFO full, hold-off, back-to-back frames
        c0 = 1'b1;
        repeat (4) @(negedge clk);
        check("t3_ready_empty", rdy0, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d0 = 8'(i + 1);
            v0 = 1'b1;
        end
        @(negedge clk);
        check("t3_ready_full", rdy0, 0);
        d0 = 8'h05;
        stayed = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rdy0 !== 1'b0) stayed = 1'b0;
        end
        check("t3_ready_held_off", stayed, 1);
        v0 = 1'b0;
        c0 = 1'b0;
        k = cyc + 1;
        @(negedge clk);
        check("t3_ready_k", rdy0, 0);
        @(negedge clk);
        check("t3_ready_k1", rdy0, 0);
        @(negedge clk);
        check("t3_ready_after_pop", rdy0, 1);
        last = 0;
        for (int f = 0; f < 4; f++) begin
            wait_fall(0, 20, t, ok);
            check("t3_fall_seen", ok, 1);
            if (f == 0) check("t3_first_latency", t - k, 3);
            else        check("t3_gap", t - last, 2);
            read_frame(0, 10, fr, st);
            check("t3_stable", st, 1);
            check("t3_frame", fr, build_frame(8'(f + 1), 0, 0));
            last = cyc;
        end
        repeat (3) @(negedge clk);
        check("t3_no_fifth", rts0, 1);

        // Parity table: odd/2-stop on dut1, even/1-stop on dut2
        for (int i = 0; i < 6; i++) begin
            push1(tbl[i].data, n);
            fork
                begin
                    wait_fall(1, 20, t1, ok1);
                    read_frame(1, 12, f1, s1);
                end
                begin
                    wait_fall(2, 20, t2, ok2);
                    read_frame(2, 11, f2, s2);
                end
            join
            e1 = '1;
            e1[0] = 1'b0;
            e1[8:1] = tbl[i].data;
            e1[9] = tbl[i].par_odd;
            e2 = '1;
            e2[0] = 1'b0;
            e2[8:1] = tbl[i].data;
            e2[9] = tbl[i].par_even;
            check("t4_fall_seen", {ok1, ok2}, 2'b11);
            check("t4_latency", t1 - n, 3);
            check("t4_aligned", t2 - t1, 0);
            check("t4_stable", {s1, s2}, 2'b11);
            check("t4_frame_odd", f1, e1);
            check("t4_frame_even", f2, e2);
            check("t4_rts_last_stop", rts1, 0);
            @(negedge clk);
            check("t4_rts_after_192", rts1, 1);
            check("t4_tx_idle", tx1, 1);
        end

        // Reset mid-frame with bytes queued
        @(negedge clk);
        d0 = 8'h55;
        v0 = 1'b1;
        @(negedge clk);
        d0 = 8'h11;
        @(negedge clk);
        d0 = 8'h22;
        @(negedge clk);
        v0 = 1'b0;
        wait_fall(0, 20, t, ok);
        check("t5_fall_seen", ok, 1);
        repeat (5 * C + 8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_async_tx", tx0, 1);
        check("t5_async_rts", rts0, 1);
        check("t5_async_busy", busy0, 0);
        check("t5_async_ready", rdy0, 1);
        @(negedge clk);
        rst = 1'b0;
        stayed = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || rts0 !== 1'b1) stayed = 1'b0;
        end
        check("t5_idle_after_reset", stayed, 1);
        push0(8'h0F, n);
        wait_fall(0, 20, t, ok);
        check("t5_fall_seen2", ok, 1);
        check("t5_latency", t - n, 3);
        read_frame(0, 10, fr, st);
        check("t5_stable", st, 1);
        check("t5_frame", fr, build_frame(8'h0F, 0, 0));
        repeat (3) @(negedge clk);

        // Push coinciding with the WAIT_CTS pop
        c0 = 1'b1;
        repeat (4) @(negedge clk);
        @(negedge clk);
        d0 = 8'hA1;
        v0 = 1'b1;
        @(negedge clk);
        d0 = 8'hB2;
        @(negedge clk);
        d0 = 8'hC3;
        @(negedge clk);
        v0 = 1'b0;
        c0 = 1'b0;
        k = cyc + 1;
        @(negedge clk);
        @(negedge clk);
        d0 = 8'hD4;
        v0 = 1'b1;
        check("t6_ready_before", rdy0, 1);
        @(negedge clk);
        v0 = 1'b0;
        check("t6_count_kept", rdy0, 1);
        d0 = 8'hE5;
        v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        check("t6_full_after_extra", rdy0, 0);
        check("t6_fall_at_k3", tx0, 0);
        t = cyc;
        check("t6_latency", t - k, 3);
        for (int f = 0; f < 5; f++) begin
            logic [7:0] exp_b;
            case (f)
                0: exp_b = 8'hA1;
                1: exp_b = 8'hB2;
                2: exp_b = 8'hC3;
                3: exp_b = 8'hD4;
                default: exp_b = 8'hE5;
            endcase
            if (f > 0) begin
                wait_fall(0, 20, t, ok);
                check("t6_fall_seen", ok, 1);
                check("t6_gap", t - last, 2);
            end
            read_frame(0, 10, fr, st);
            check("t6_stable", st, 1);
            check("t6_frame", fr, build_frame(exp_b, 0, 0));
            last = cyc;
        end
        repeat (3) @(negedge clk);

        // Randomised stream with random CTS, checked against a byte queue
        q.delete();
        fork
            begin
                for (int i = 0; i < 3000; i++) begin
                    @(negedge clk);
                    v0 = ($urandom_range(0, 9) == 0);
                    d0 = 8'($urandom);
                    if ($urandom_range(0, 49) == 0) c0 = ~c0;
                    if (v0 && rdy0) q.push_back(d0);
                end
                @(negedge clk);
                v0 = 1'b0;
                c0 = 1'b0;
                drv_done = 1'b1;
            end
            begin
                idle = 0;
                forever begin
                    @(negedge clk);
                    if (tx0 == 1'b0) begin
                        logic [7:0] exp_b;
                        check("rnd_expected_frame", (q.size() > 0), 1);
                        check("rnd_cts_asserted", cts_d[3], 0);
                        exp_b = (q.size() > 0) ? q.pop_front() : 8'h00;
                        read_frame(0, 10, fr, st);
                        check("rnd_stable", st, 1);
                        check("rnd_frame", fr, build_frame(exp_b, 0, 0));
                        idle = 0;
                    end else begin
                        idle++;
                        if (drv_done && q.size() == 0) break;
                        if (idle > 5000) begin
                            check("rnd_drain_timeout", idle, 0);
                            break;
                        end
                    end
                end
            end
        join
        check("rnd_queue_empty", q.size(), 0);
        repeat (3) @(negedge clk);
        check("rnd_final_rts", rts0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_fc.md
Name: uart_tx_fc

Overview:
- UART transmitter for the host end of the RTS/CTS link, complementing the existing uart_rtl interface (rx/tx/rts/cts).
- Accepts bytes over a valid/ready stream into a small FIFO and serialises them on tx as 8N1 frames, with optional parity and optional 2 stop bits.
- Drives rts (active-low) while it has data to send. A new frame starts only while cts (active-low) is asserted.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200). Minimum 4.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity. Ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits: 1 or 2.
- FIFO_DEPTH, 4, byte entries. Must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tx_data  in  8  byte to send
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  FIFO can accept a byte; equals !full (combinational)
- tx  out  1  serial line; idles high
- rts  out  1  request-to-send, active-low
- cts  in  1  clear-to-send, active-low, asynchronous to clk
- busy  out  1  a frame is in progress or the FIFO is non-empty

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: tx=1, rts=1, busy=0, tx_ready=1. FIFO is emptied, FSM goes to IDLE, counters are 0. Reset mid-frame aborts the frame immediately; tx returns high on the same edge.
- Push: a byte is written when tx_valid && tx_ready at a clk edge.
  - Push while full is impossible, because tx_ready=0 when full.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- CTS input: passes through a 2-flop synchroniser to give cts_s. The FSM uses only cts_s.
- RTS output: registered. rts=0 when the FIFO is non-empty or the FSM is not IDLE; otherwise rts=1.
- busy: registered, with the same condition as rts (inverted polarity).
- FSM states: IDLE, WAIT_CTS, START, DATA, PARITY, STOP.
  - IDLE: when the FIFO is non-empty, go to WAIT_CTS.
  - WAIT_CTS: while cts_s=1, hold with tx=1. When cts_s=0, pop the FIFO head into the shift register, clear the bit counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. Then go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx = XOR of data bits, XOR PARITY_ODD.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. Then go to WAIT_CTS if the FIFO is non-empty (back-to-back frames with no idle gap beyond the CTS check), else IDLE.
- CTS is sampled only in WAIT_CTS. Deassertion mid-frame never truncates or stalls the current frame.
- tx is registered. No glitches at bit boundaries.
- Latency: with an empty FIFO and cts held low (already synchronised):
  - push at edge N;
  - IDLE→WAIT_CTS at N+1;
  - pop at N+2;
  - tx falls at edge N+3.
- Frame length: (1 + 8 + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles exactly.
- Baud counter: counts 0..CLKS_PER_BIT-1 and is reset on every state entry.

Test Plan:
- Single byte, CLKS_PER_BIT=16, no parity, 1 stop bit, cts=0. Push 0xA5 -> tx falls 3 cycles after the push. Bit sequence is 0,1,0,1,0,0,1,0,1,1, each 16 cycles wide (160 total). rts goes low 1 cycle after the push and returns high 1 cycle after the stop bit ends. busy tracks rts inverted.
- CTS gating: hold cts=1 and push 0x3C -> rts=0, tx stays 1 indefinitely. Drop cts -> tx falls 3 cycles later (2 synchroniser + 1). Raise cts at bit 3 -> the frame completes intact.
- FIFO full and back-to-back: push 0x01..0x04 continuously -> tx_ready=0 after the 4th push (a 5th valid is held off). The first byte pops immediately, so tx_ready reasserts one cycle after that pop. Four frames go out contiguously: each stop bit is followed by the next start bit after exactly 2 cycles (STOP→WAIT_CTS→START). Byte order 0x01..0x04.
- Parity/stop: PARITY_EN=1, PARITY_ODD=1, STOP_BITS=2, byte 0x07 -> parity bit = 0. The frame is 12*16 = 192 cycles with 2 high stop bits. With even parity the same byte gives parity bit 1.
- Reset mid-frame: assert rst during DATA bit 4 of 0x55 with 2 bytes queued -> tx=1, rts=1, busy=0, tx_ready=1 asynchronously. After release, with no new push, tx stays idle. A new push of 0x0F transmits correctly.
- Simultaneous push/pop: FIFO holds 3 bytes and a push coincides with a WAIT_CTS pop -> count stays 3, the pushed byte is transmitted last, no loss or duplication.
